uart_rx_word32: RTL and testbench
=================================

// Module: uart_rx_word32
// PURPOSE
//  Receive side of the 32-bit UART link: deserialises 8N1 UART bytes and packs
//  four of them into one 32-bit word. Pairs with the 32-bit word transmitter
//  (byte 0 = bits [7:0] sent first). Sits between the board RX pin and the SoC
//  bus/IO register that consumes received words.
// PARAMETERS
//  CLKS_PER_BIT  87  clocks per UART bit (10 MHz / 115200); must be >= 8
//  TIMEOUT_BITS  20  inter-byte idle gap, in bit periods, that aborts a partial word
// PORTS
//  i_Clock        in   1   system clock; all logic on rising edge
//  i_Rst_n        in   1   reset; asynchronous, active-low
//  i_Rx_Serial    in   1   asynchronous UART line; idles high
//  o_Rx_Word      out  32  last complete word; held until next word completes
//  o_Rx_DV        out  1   one-cycle pulse: o_Rx_Word just updated
//  o_Byte_Cnt     out  2   bytes of the current partial word received (0..3)
//  o_Rx_Active    out  1   high from start-bit detect to end of CLEANUP
//  o_Frame_Err    out  1   one-cycle pulse: stop bit sampled low
//  o_Timeout_Err  out  1   one-cycle pulse: partial word dropped on idle timeout
// BEHAVIOUR
//  Reset: o_Rx_Word=0, all pulses/o_Rx_Active=0, o_Byte_Cnt=0, FSM=IDLE,
//   synchroniser flops=1, clock/timeout counters=0. Reset mid-byte/mid-word
//   abandons all partial data; no pulse is emitted.
//  Input: 2-flop synchroniser on i_Rx_Serial; all sampling uses its output.
//  FSM (clock counter clk_cnt, bit index bit_idx 0..7):
//   IDLE : sync line==0 -> START, clk_cnt=0.
//   START: at clk_cnt==(CLKS_PER_BIT-1)/2 sample; 0 -> DATA, clk_cnt=0;
//          1 -> false start, IDLE (no pulse, partial word kept).
//   DATA : every CLKS_PER_BIT clocks sample into byte[bit_idx], LSB first;
//          after bit 7 -> STOP.
//   STOP : after CLKS_PER_BIT clocks sample stop bit:
//          1 -> byte stored in word slot o_Byte_Cnt; o_Byte_Cnt wraps 3->0; on
//               the 4th byte, o_Rx_Word <= {b3,b2,b1,b0} and o_Rx_DV pulses on
//               the next cycle (same edge that loads o_Rx_Word).
//          0 -> o_Frame_Err pulse, partial word discarded, o_Byte_Cnt=0.
//          -> CLEANUP.
//   CLEANUP: one cycle, -> IDLE.
//  Timeout: in IDLE with o_Byte_Cnt!=0, count clocks; at
//   TIMEOUT_BITS*CLKS_PER_BIT -> o_Timeout_Err pulse, o_Byte_Cnt=0. Counter
//   clears on leaving IDLE or when o_Byte_Cnt==0. Start edge on the same cycle
//   as expiry: timeout wins, new byte is slot 0.
//  o_Rx_Word is only written on a complete good word; errors never corrupt it.
//  No backpressure: a new word overwrites o_Rx_Word; consumer must sample on DV.
//  Latency: o_Rx_DV rises 2 (sync) + 1 clocks after mid-stop-bit of byte 3.
//  Back-to-back bytes (start immediately after stop) must be received; the
//   half-bit of stop remaining after sampling covers CLEANUP.
//  Counters sized $clog2 of their maxima; no wrap within legal operation.
// TESTING
//  1 Bytes 0x78,0x56,0x34,0x12 at 8680 ns/bit -> one o_Rx_DV, o_Rx_Word=0x12345678.
//  2 Loopback with 32-bit transmitter sending 0xFFFFFFFE -> o_Rx_Word=0xFFFFFFFE,
//    no error pulses.
//  3 Line low 20 clocks then high -> no pulses, o_Byte_Cnt unchanged, FSM to IDLE.
//  4 2nd byte with stop bit 0 -> o_Frame_Err 1 cycle, o_Byte_Cnt=0; next 4 good
//    bytes 0xEF,0xBE,0xAD,0xDE -> o_Rx_Word=0xDEADBEEF.
//  5 Two bytes, then idle 1740 clocks -> o_Timeout_Err pulse, o_Byte_Cnt=0,
//    o_Rx_Word unchanged.
//  6 i_Rst_n low during 3rd byte -> all outputs reset; following 4 bytes give
//    the correct word with no stale data.

Source files
------------

// File: rtl/uart_rx_word32_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_word32_if
//  Brief    : Output bundle of the 32-bit UART word receiver. The receiver
//             drives it through the master modport; the consumer reads it
//             through the slave modport.
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_word32_if;
   logic [31:0] o_Rx_Word;
   logic        o_Rx_DV;
   logic [1:0]  o_Byte_Cnt;
   logic        o_Rx_Active;
   logic        o_Frame_Err;
   logic        o_Timeout_Err;

   modport master (
      output o_Rx_Word,
      output o_Rx_DV,
      output o_Byte_Cnt,
      output o_Rx_Active,
      output o_Frame_Err,
      output o_Timeout_Err
   );

   modport slave (
      input o_Rx_Word,
      input o_Rx_DV,
      input o_Byte_Cnt,
      input o_Rx_Active,
      input o_Frame_Err,
      input o_Timeout_Err
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx_word32.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_word32
//  Brief    : 8N1 UART receiver that packs four bytes (first byte = [7:0])
//             into one 32-bit word, with frame-error and inter-byte idle
//             timeout detection.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_word32 #(
   parameter int unsigned CLKS_PER_BIT = 87,
   parameter int unsigned TIMEOUT_BITS = 20
) (
   input  logic             i_Clock,
   input  logic             i_Rst_n,
   input  logic             i_Rx_Serial,
   uart_rx_word32_if.master rx_bus
);

   localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
   localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int unsigned TO_W     = $clog2(TO_LIMIT);

   localparam logic [CNT_W-1:0] c_bit_last = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] c_half     = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [TO_W-1:0]  c_to_last  = TO_W'(TO_LIMIT - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_STOP    = 3'd3,
      ST_CLEANUP = 3'd4
   } state_t;

   state_t            state_q,       state_d;
   logic              sync1_q,       sync1_d;
   logic              sync2_q,       sync2_d;
   logic [CNT_W-1:0]  clk_cnt_q,     clk_cnt_d;
   logic [2:0]        bit_idx_q,     bit_idx_d;
   logic [7:0]        shift_q,       shift_d;
   logic [23:0]       slots_q,       slots_d;
   logic [1:0]        byte_cnt_q,    byte_cnt_d;
   logic [TO_W-1:0]   to_cnt_q,      to_cnt_d;
   logic [31:0]       rx_word_q,     rx_word_d;
   logic              rx_dv_q,       rx_dv_d;
   logic              rx_active_q,   rx_active_d;
   logic              frame_err_q,   frame_err_d;
   logic              timeout_err_q, timeout_err_d;

   logic              w_rx;

   assign w_rx = sync2_q;

   // Next-state logic: synchroniser, bit-level FSM, byte packing and idle timeout
   always_comb begin
      sync1_d       = i_Rx_Serial;
      sync2_d       = sync1_q;
      state_d       = state_q;
      clk_cnt_d     = clk_cnt_q;
      bit_idx_d     = bit_idx_q;
      shift_d       = shift_q;
      slots_d       = slots_q;
      byte_cnt_d    = byte_cnt_q;
      to_cnt_d      = to_cnt_q;
      rx_word_d     = rx_word_q;
      rx_dv_d       = 1'b0;
      frame_err_d   = 1'b0;
      timeout_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            clk_cnt_d = '0;
            bit_idx_d = '0;
            // Idle gap inside a partial word: abandon it once the limit is hit
            if (byte_cnt_q != 2'd0) begin
               if (to_cnt_q == c_to_last) begin
                  timeout_err_d = 1'b1;
                  byte_cnt_d    = 2'd0;
                  to_cnt_d      = '0;
               end else begin
                  to_cnt_d = to_cnt_q + 1'b1;
               end
            end else begin
               to_cnt_d = '0;
            end
            // A start edge coinciding with expiry still starts a byte, now in slot 0
            if (!w_rx) begin
               state_d  = ST_START;
               to_cnt_d = '0;
            end
         end

         ST_START: begin
            if (clk_cnt_q == c_half) begin
               clk_cnt_d = '0;
               state_d   = w_rx ? ST_IDLE : ST_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end

         ST_DATA: begin
            if (clk_cnt_q == c_bit_last) begin
               clk_cnt_d = '0;
               shift_d   = {w_rx, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  bit_idx_d = '0;
                  state_d   = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end

         ST_STOP: begin
            if (clk_cnt_q == c_bit_last) begin
               clk_cnt_d = '0;
               state_d   = ST_CLEANUP;
               if (w_rx) begin
                  case (byte_cnt_q)
                     2'd0:    slots_d[7:0]   = shift_q;
                     2'd1:    slots_d[15:8]  = shift_q;
                     2'd2:    slots_d[23:16] = shift_q;
                     default: begin
                        rx_word_d = {shift_q, slots_q};
                        rx_dv_d   = 1'b1;
                     end
                  endcase
                  // Wraps 3 -> 0 when the word completes
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end else begin
                  frame_err_d = 1'b1;
                  byte_cnt_d  = 2'd0;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end

         ST_CLEANUP: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase

      rx_active_d = (state_d != ST_IDLE);
   end

   // State and registered outputs; line synchroniser resets to idle-high
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q       <= ST_IDLE;
         sync1_q       <= 1'b1;
         sync2_q       <= 1'b1;
         clk_cnt_q     <= '0;
         bit_idx_q     <= '0;
         shift_q       <= '0;
         slots_q       <= '0;
         byte_cnt_q    <= '0;
         to_cnt_q      <= '0;
         rx_word_q     <= '0;
         rx_dv_q       <= 1'b0;
         rx_active_q   <= 1'b0;
         frame_err_q   <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         clk_cnt_q     <= clk_cnt_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         slots_q       <= slots_d;
         byte_cnt_q    <= byte_cnt_d;
         to_cnt_q      <= to_cnt_d;
         rx_word_q     <= rx_word_d;
         rx_dv_q       <= rx_dv_d;
         rx_active_q   <= rx_active_d;
         frame_err_q   <= frame_err_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign rx_bus.o_Rx_Word     = rx_word_q;
   assign rx_bus.o_Rx_DV       = rx_dv_q;
   assign rx_bus.o_Byte_Cnt    = byte_cnt_q;
   assign rx_bus.o_Rx_Active   = rx_active_q;
   assign rx_bus.o_Frame_Err   = frame_err_q;
   assign rx_bus.o_Timeout_Err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_word32.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_uart_rx_word32
//  Brief    : Self-checking bench for uart_rx_word32: directed word table,
//             framing/timeout/reset corner cases and randomized words checked
//             against a byte-queue reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_word32;

   localparam int CPB = 87;
   localparam int TOB = 20;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rx_line = 1'b1;

   uart_rx_word32_if bus ();

   uart_rx_word32 #(
      .CLKS_PER_BIT (CPB),
      .TIMEOUT_BITS (TOB)
   ) dut (
      .i_Clock     (clk),
      .i_Rst_n     (rst_n),
      .i_Rx_Serial (rx_line),
      .rx_bus      (bus)
   );

   // 10 MHz system clock
   always #50 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   int dv_cnt   = 0;
   int ferr_cnt = 0;
   int terr_cnt = 0;
   logic prev_dv = 1'b0, prev_ferr = 1'b0, prev_terr = 1'b0;

   // Reference model: bytes of the partial word plus event counts
   logic [7:0]  m_part[$];
   logic [31:0] m_word = 32'h0;
   int m_dv = 0, m_ferr = 0, m_terr = 0;

   typedef struct {
      logic [31:0] data;
      int          bad_idx;
      logic [31:0] exp_word;
      int          exp_dv;
      int          exp_ferr;
      int          exp_cnt;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx_line = 1'b0;
      wait_clks(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_line = b[i];
         wait_clks(CPB);
      end
      rx_line = stop_bit;
      wait_clks(CPB);
      rx_line = 1'b1;
      if (!stop_bit) wait_clks(CPB);
   endtask

   task automatic model_byte(input logic [7:0] b, input logic ok);
      if (!ok) begin
         m_part.delete();
         m_ferr++;
      end else begin
         m_part.push_back(b);
         if (m_part.size() == 4) begin
            m_word = {m_part[3], m_part[2], m_part[1], m_part[0]};
            m_dv++;
            m_part.delete();
         end
      end
   endtask

   task automatic check_model(input string tag);
      check($sformatf("%s word", tag), bus.o_Rx_Word, m_word);
      check($sformatf("%s dv_count", tag), dv_cnt, m_dv);
      check($sformatf("%s ferr_count", tag), ferr_cnt, m_ferr);
      check($sformatf("%s terr_count", tag), terr_cnt, m_terr);
      check($sformatf("%s byte_cnt", tag), 32'(bus.o_Byte_Cnt), m_part.size());
   endtask

   // Pulse monitor: counts events and requires each pulse to last one cycle
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.o_Rx_DV) begin
            dv_cnt++;
            check("dv_one_cycle", 32'(prev_dv), 32'd0);
         end
         if (bus.o_Frame_Err) begin
            ferr_cnt++;
            check("ferr_one_cycle", 32'(prev_ferr), 32'd0);
         end
         if (bus.o_Timeout_Err) begin
            terr_cnt++;
            check("terr_one_cycle", 32'(prev_terr), 32'd0);
         end
      end
      prev_dv   = bus.o_Rx_DV;
      prev_ferr = bus.o_Frame_Err;
      prev_terr = bus.o_Timeout_Err;
   end

   initial begin
      logic [31:0] dw;
      logic [7:0]  b;
      logic        ok;
      int d0, f0, t0, wait_n;
      bit  bad;

      tbl[0] = '{32'h12345678, -1, 32'h12345678, 1, 0, 0};
      tbl[1] = '{32'hFFFFFFFE, -1, 32'hFFFFFFFE, 1, 0, 0};
      tbl[2] = '{32'h00000000, -1, 32'h00000000, 1, 0, 0};
      tbl[3] = '{32'h00001111,  1, 32'h00000000, 0, 1, 0};
      tbl[4] = '{32'hDEADBEEF, -1, 32'hDEADBEEF, 1, 0, 0};
      tbl[5] = '{32'h80000001, -1, 32'h80000001, 1, 0, 0};

      // Reset state
      rst_n   = 1'b0;
      rx_line = 1'b1;
      wait_clks(5);
      check("rst word", bus.o_Rx_Word, 32'h0);
      check("rst dv", 32'(bus.o_Rx_DV), 32'd0);
      check("rst byte_cnt", 32'(bus.o_Byte_Cnt), 32'd0);
      check("rst active", 32'(bus.o_Rx_Active), 32'd0);
      check("rst ferr", 32'(bus.o_Frame_Err), 32'd0);
      check("rst terr", 32'(bus.o_Timeout_Err), 32'd0);
      rst_n = 1'b1;
      wait_clks(10);

      // Directed word table
      for (int i = 0; i < 6; i++) begin
         d0 = dv_cnt; f0 = ferr_cnt; t0 = terr_cnt;
         dw = tbl[i].data;
         for (int k = 0; k < 4; k++) begin
            bad = (k == tbl[i].bad_idx);
            send_byte(dw[8*k +: 8], !bad);
            model_byte(dw[8*k +: 8], !bad);
            if (bad) break;
         end
         wait_clks(4);
         check($sformatf("tbl%0d word", i), bus.o_Rx_Word, tbl[i].exp_word);
         check($sformatf("tbl%0d dv", i), dv_cnt - d0, tbl[i].exp_dv);
         check($sformatf("tbl%0d ferr", i), ferr_cnt - f0, tbl[i].exp_ferr);
         check($sformatf("tbl%0d terr", i), terr_cnt - t0, 32'd0);
         check($sformatf("tbl%0d byte_cnt", i), 32'(bus.o_Byte_Cnt), tbl[i].exp_cnt);
      end

      // False start with one byte of a word pending
      send_byte(8'h5A, 1'b1);
      model_byte(8'h5A, 1'b1);
      check("pre_glitch byte_cnt", 32'(bus.o_Byte_Cnt), 32'd1);
      rx_line = 1'b0;
      wait_clks(20);
      rx_line = 1'b1;
      wait_clks(CPB);
      check("glitch active", 32'(bus.o_Rx_Active), 32'd0);
      check_model("glitch");

      // Second byte, then idle until the partial word times out
      send_byte(8'hC3, 1'b1);
      model_byte(8'hC3, 1'b1);
      t0 = terr_cnt;
      wait_clks(1650);
      check("to_early terr", terr_cnt - t0, 32'd0);
      check("to_early byte_cnt", 32'(bus.o_Byte_Cnt), 32'd2);
      wait_n = 0;
      while (terr_cnt == t0 && wait_n < 200) begin
         wait_clks(1);
         wait_n++;
      end
      check("to_fire terr", terr_cnt - t0, 32'd1);
      m_terr++;
      m_part.delete();
      wait_clks(2);
      check_model("timeout");

      // Reset during the third byte
      send_byte(8'h11, 1'b1);
      model_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      model_byte(8'h22, 1'b1);
      rx_line = 1'b0;
      wait_clks(CPB * 3);
      check("mid_byte active", 32'(bus.o_Rx_Active), 32'd1);
      rst_n = 1'b0;
      wait_clks(3);
      check("inrst word", bus.o_Rx_Word, 32'h0);
      check("inrst byte_cnt", 32'(bus.o_Byte_Cnt), 32'd0);
      check("inrst active", 32'(bus.o_Rx_Active), 32'd0);
      check("inrst dv", 32'(bus.o_Rx_DV), 32'd0);
      m_part.delete();
      m_word = 32'h0;
      rx_line = 1'b1;
      wait_clks(2);
      rst_n = 1'b1;
      wait_clks(CPB * 2);
      dw = 32'h0BADF00D;
      for (int k = 0; k < 4; k++) begin
         send_byte(dw[8*k +: 8], 1'b1);
         model_byte(dw[8*k +: 8], 1'b1);
      end
      wait_clks(4);
      check_model("post_rst");

      // Randomized bytes, gaps and occasional bad stop bits
      for (int w = 0; w < 8; w++) begin
         for (int k = 0; k < 4; k++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 9) != 0);
            send_byte(b, ok);
            model_byte(b, ok);
            wait_clks($urandom_range(0, 60));
         end
         wait_clks(2);
         check_model($sformatf("rand%0d", w));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
